timestamp_extend: RTL and testbench

Consumes the free-running binary counter value produced by the gray-to-binary converter in the local clock domain and widens it to a 64-bit monotonic timestamp. It counts wrap-arounds of the narrow counter and flags illegal jumps. On a capture strobe, such as a frame-start event from the MAC tap, it latches the current timestamp into a 2-deep buffer drained over a valid/ready stream. It sits between the timestamp CDC path and the frame metadata writer.

---
 rtl/timestamp_extend.sv | 146 ++++++++++++++
 tb/tb_timestamp_extend.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_extend.sv
// timestamp_extend
//
// Widens a free-running narrow binary counter (already in the local clock
// domain) into a monotonic OUT_WIDTH-bit timestamp by counting its
// wrap-arounds. Forward steps larger than MAX_STEP, and backward steps, are
// flagged on err and never advance the high word. A capture strobe snapshots
// the current timestamp into a 2-entry FIFO (head = output register,
// tail = skid register) drained over a valid/ready stream. Captures that find
// the FIFO full with no pop are dropped and counted.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_bin        narrow binary counter input
//   capture       single-cycle capture strobe
//   ts            extended timestamp (registered)
//   locked        high once the INIT phase has completed
//   err           one-cycle pulse on an illegal in_bin step
//   m_ts_tdata    captured timestamp (head of FIFO)
//   m_ts_tvalid   head valid
//   m_ts_tready   downstream ready
//   overflow      one-cycle pulse when a capture is dropped
//   drop_count    saturating count of dropped captures
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | waiting INIT_CYCLES cycles for in_bin to settle; ts held 0
// ST_RUN  | tracking in_bin, extending ts, accepting captures

module timestamp_extend #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 64,
    parameter int MAX_STEP    = 16,
    parameter int INIT_CYCLES = 2,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_bin,
    input  logic                  capture,
    output logic [OUT_WIDTH-1:0]  ts,
    output logic                  locked,
    output logic                  err,
    output logic [OUT_WIDTH-1:0]  m_ts_tdata,
    output logic                  m_ts_tvalid,
    input  logic                  m_ts_tready,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int HIGH_W = OUT_WIDTH - IN_WIDTH;
    localparam int CNT_W  = $clog2(INIT_CYCLES + 1);
    localparam logic [IN_WIDTH-1:0] MAX_STEP_V  = IN_WIDTH'(MAX_STEP);
    localparam logic [CNT_W-1:0]    INIT_LOAD_V = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      init_cnt;
    logic [IN_WIDTH-1:0]   prev;
    logic [HIGH_W-1:0]     high;
    logic [OUT_WIDTH-1:0]  skid_data;
    logic                  skid_valid;

    logic [IN_WIDTH-1:0]   delta;
    logic                  step_bad;
    logic                  wrap;
    logic [HIGH_W-1:0]     high_next;
    logic                  push;
    logic                  pop;

    always_comb begin
        delta     = in_bin - prev;
        step_bad  = (delta > MAX_STEP_V);
        // A legal step that lands below prev must have crossed zero.
        wrap      = !step_bad && (in_bin < prev);
        high_next = high + HIGH_W'(wrap);
        push      = capture && (state == ST_RUN);
        pop       = m_ts_tvalid && m_ts_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= INIT_LOAD_V;
            prev        <= '0;
            high        <= '0;
            ts          <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            m_ts_tdata  <= '0;
            m_ts_tvalid <= 1'b0;
            skid_data   <= '0;
            skid_valid  <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            err      <= 1'b0;
            overflow <= 1'b0;

            case (state)
                ST_INIT: begin
                    if (init_cnt == '0) begin
                        prev   <= in_bin;
                        high   <= '0;
                        locked <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    prev <= in_bin;
                    high <= high_next;
                    ts   <= {high_next, in_bin};
                    err  <= step_bad;
                end
                default: state <= ST_INIT;
            endcase

            // Two-entry FIFO. The head only ever refills from the skid first,
            // so FIFO order is kept; the skid is never valid with an empty head.
            if (pop) begin
                if (skid_valid) begin
                    m_ts_tdata <= skid_data;
                    skid_valid <= push;
                    if (push) skid_data <= ts;
                end else begin
                    m_ts_tvalid <= push;
                    if (push) m_ts_tdata <= ts;
                end
            end else if (push) begin
                if (!m_ts_tvalid) begin
                    m_ts_tdata  <= ts;
                    m_ts_tvalid <= 1'b1;
                end else if (!skid_valid) begin
                    skid_data  <= ts;
                    skid_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (drop_count != '1) drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timestamp_extend.sv
// tb_timestamp_extend
//
// Directed bench for timestamp_extend. Inputs are driven 1 ns after each
// rising edge and outputs are checked at that same point, so every check sees
// the state produced by the edge just taken. DROP_WIDTH is shrunk to 3 so
// counter saturation can be reached in a few cycles.

module tb_timestamp_extend;

    logic        clk;
    logic        rst;
    logic [31:0] in_bin;
    logic        capture;
    logic [63:0] ts;
    logic        locked;
    logic        err;
    logic [63:0] m_ts_tdata;
    logic        m_ts_tvalid;
    logic        m_ts_tready;
    logic        overflow;
    logic [2:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    timestamp_extend #(
        .IN_WIDTH(32), .OUT_WIDTH(64), .MAX_STEP(16),
        .INIT_CYCLES(2), .DROP_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .in_bin(in_bin), .capture(capture),
        .ts(ts), .locked(locked), .err(err),
        .m_ts_tdata(m_ts_tdata), .m_ts_tvalid(m_ts_tvalid),
        .m_ts_tready(m_ts_tready), .overflow(overflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start);
        rst = 1'b1; capture = 1'b0; in_bin = start;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_bin = 32'h10; capture = 1'b0; m_ts_tready = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (ts !== 64'h0 || locked !== 1'b0 || m_ts_tvalid !== 1'b0 || drop_count !== 3'd0
            || err !== 1'b0 || overflow !== 1'b0 || m_ts_tdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_values: ts=%h locked=%b tvalid=%b drop=%0d err=%b ovf=%b tdata=%h, required all zero",
                     ts, locked, m_ts_tvalid, drop_count, err, overflow, m_ts_tdata);
        end
        rst = 1'b0; in_bin = 32'h10; capture = 1'b1;
        tick();
        n_tests++;
        if (locked !== 1'b0 || ts !== 64'h0) begin
            n_fail++;
            $display("FAIL init_cycle1: locked=%b ts=%h, required 0 / 0", locked, ts);
        end
        in_bin = 32'h11; capture = 1'b1;
        tick();
        n_tests++;
        if (locked !== 1'b1 || ts !== 64'h0 || m_ts_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: locked=%b ts=%h tvalid=%b, required 1 / 0 / 0", locked, ts, m_ts_tvalid);
        end
        in_bin = 32'h12; capture = 1'b0;
        tick();
        n_tests++;
        if (ts !== 64'h0000_0000_0000_0012 || m_ts_tvalid !== 1'b0 || drop_count !== 3'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL first_ts: ts=%h tvalid=%b drop=%0d err=%b, required 12 / 0 / 0 / 0",
                     ts, m_ts_tvalid, drop_count, err);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        logic [63:0] exp [4];
        seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        exp = '{64'h0_FFFF_FFFE, 64'h0_FFFF_FFFF, 64'h1_0000_0000, 64'h1_0000_0001};
        do_reset(32'hFFFF_FFFD);
        for (int i = 0; i < 4; i++) begin
            in_bin = seq[i];
            tick();
            n_tests++;
            if (ts !== exp[i] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: ts=%h err=%b, required %h / 0", i, ts, err, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic saw_err;
        do_reset(32'hFFFF_FFFF);
        in_bin = 32'h0;
        tick();
        saw_err = err;
        for (int v = 32'h10; v <= 32'h100; v += 32'h10) begin
            in_bin = 32'(v);
            tick();
            saw_err = saw_err | err;
        end
        n_tests++;
        if (saw_err !== 1'b0 || ts !== 64'h1_0000_0100) begin
            n_fail++;
            $display("FAIL max_step_legal: err_seen=%b ts=%h, required 0 / 100000100", saw_err, ts);
        end
        in_bin = 32'h164;
        tick();
        n_tests++;
        if (err !== 1'b1 || ts !== 64'h1_0000_0164) begin
            n_fail++;
            $display("FAIL jump_fwd: err=%b ts=%h, required 1 / 100000164", err, ts);
        end
        tick();
        n_tests++;
        if (err !== 1'b0 || ts !== 64'h1_0000_0164) begin
            n_fail++;
            $display("FAIL stall_after_err: err=%b ts=%h, required 0 / 100000164", err, ts);
        end
        in_bin = 32'h150;
        tick();
        n_tests++;
        if (err !== 1'b1 || ts !== 64'h1_0000_0150) begin
            n_fail++;
            $display("FAIL jump_back: err=%b ts=%h, required 1 / 100000150", err, ts);
        end
        in_bin = 32'h151;
        tick();
        n_tests++;
        if (err !== 1'b0 || ts !== 64'h1_0000_0151) begin
            n_fail++;
            $display("FAIL after_back: err=%b ts=%h, required 0 / 100000151", err, ts);
        end
        in_bin = 32'h162;
        tick();
        n_tests++;
        if (err !== 1'b1 || ts !== 64'h1_0000_0162) begin
            n_fail++;
            $display("FAIL step_17: err=%b ts=%h, required 1 / 100000162", err, ts);
        end
    endtask

    task automatic test_overflow();
        do_reset(32'h1000);
        m_ts_tready = 1'b0;
        in_bin = 32'h1001;
        tick();
        capture = 1'b1; in_bin = 32'h1002;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b1 || m_ts_tdata !== 64'h1001 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_latency: tvalid=%b tdata=%h ovf=%b, required 1 / 1001 / 0",
                     m_ts_tvalid, m_ts_tdata, overflow);
        end
        in_bin = 32'h1003;
        tick();
        n_tests++;
        if (m_ts_tdata !== 64'h1001 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_second: tdata=%h ovf=%b, required 1001 / 0", m_ts_tdata, overflow);
        end
        in_bin = 32'h1004;
        tick();
        n_tests++;
        if (overflow !== 1'b1 || drop_count !== 3'd1 || m_ts_tdata !== 64'h1001) begin
            n_fail++;
            $display("FAIL cap_drop: ovf=%b drop=%0d tdata=%h, required 1 / 1 / 1001",
                     overflow, drop_count, m_ts_tdata);
        end
        capture = 1'b0; in_bin = 32'h1005;
        tick();
        n_tests++;
        if (overflow !== 1'b0 || m_ts_tvalid !== 1'b1 || m_ts_tdata !== 64'h1001 || drop_count !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_stable: ovf=%b tvalid=%b tdata=%h drop=%0d, required 0 / 1 / 1001 / 1",
                     overflow, m_ts_tvalid, m_ts_tdata, drop_count);
        end
        m_ts_tready = 1'b1;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b1 || m_ts_tdata !== 64'h1002) begin
            n_fail++;
            $display("FAIL drain_b: tvalid=%b tdata=%h, required 1 / 1002", m_ts_tvalid, m_ts_tdata);
        end
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: tvalid=%b, required 0", m_ts_tvalid);
        end
    endtask

    task automatic test_full_pop();
        m_ts_tready = 1'b0; capture = 1'b1;
        in_bin = 32'h1006;
        tick();
        in_bin = 32'h1007;
        tick();
        m_ts_tready = 1'b1; in_bin = 32'h1008;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b1 || m_ts_tdata !== 64'h1006 || overflow !== 1'b0 || drop_count !== 3'd1) begin
            n_fail++;
            $display("FAIL full_pop: tvalid=%b tdata=%h ovf=%b drop=%0d, required 1 / 1006 / 0 / 1",
                     m_ts_tvalid, m_ts_tdata, overflow, drop_count);
        end
        capture = 1'b0;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b1 || m_ts_tdata !== 64'h1007) begin
            n_fail++;
            $display("FAIL full_pop_new: tvalid=%b tdata=%h, required 1 / 1007", m_ts_tvalid, m_ts_tdata);
        end
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_empty: tvalid=%b, required 0", m_ts_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        m_ts_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            capture = 1'b1;
            exp = 64'h1008 + 64'(i);
            in_bin = 32'h1009 + 32'(i);
            tick();
            n_tests++;
            if (m_ts_tvalid !== 1'b1 || m_ts_tdata !== exp || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b[%0d]: tvalid=%b tdata=%h ovf=%b, required 1 / %h / 0",
                         i, m_ts_tvalid, m_ts_tdata, overflow, exp);
            end
        end
        capture = 1'b0;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: tvalid=%b, required 0", m_ts_tvalid);
        end
    endtask

    task automatic test_saturate();
        m_ts_tready = 1'b0; capture = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (drop_count !== 3'd7 || overflow !== 1'b1 || m_ts_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_saturate: drop=%0d ovf=%b tvalid=%b, required 7 / 1 / 1",
                     drop_count, overflow, m_ts_tvalid);
        end
        capture = 1'b0;
        tick();
        n_tests++;
        if (overflow !== 1'b0 || drop_count !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_hold: ovf=%b drop=%0d, required 0 / 7", overflow, drop_count);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            in_bin = 32'hFFFF_FFFF; tick();
            in_bin = 32'h0;         tick();
        end
        n_tests++;
        if (ts !== 64'h3_0000_0000 || m_ts_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL high_three: ts=%h tvalid=%b, required 300000000 / 1", ts, m_ts_tvalid);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (m_ts_tvalid !== 1'b0 || ts !== 64'h0 || drop_count !== 3'd0 || locked !== 1'b0
            || overflow !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tvalid=%b ts=%h drop=%0d locked=%b ovf=%b err=%b, required all zero",
                     m_ts_tvalid, ts, drop_count, locked, overflow, err);
        end
        rst = 1'b0; in_bin = 32'h5; m_ts_tready = 1'b1;
        tick();
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_1: locked=%b, required 0", locked);
        end
        tick();
        tick();
        n_tests++;
        if (locked !== 1'b1 || ts !== 64'h5 || m_ts_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_ts: locked=%b ts=%h tvalid=%b, required 1 / 5 / 0", locked, ts, m_ts_tvalid);
        end
    endtask

    initial begin
        rst = 1'b1; in_bin = '0; capture = 1'b0; m_ts_tready = 1'b0;
        test_reset();
        test_wrap();
        test_illegal();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_saturate();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
